pyexec_host_bridge: RTL and testbench
=====================================

# pyexec_host_bridge

Synthesizable bridge between the `thiele_cpu` PYEXEC port (`py_req`/`py_code_addr`/`py_ack`/`py_result`) and a host-compute mailbox. It replaces bench-side PYEXEC servicing with hardware and adds:

- return-code enforcement;
- per-channel receipt-digest stability checking across `NUM_DIGEST` digest code addresses;
- a host watchdog;
- a selectable stop-on-error or record-and-continue mode.

## Interface

Clocking and reset: one clock; reset is synchronous and active-high.

Parameters:
- `DATA_W`, 32: code-address and result width.
- `NUM_DIGEST`, 2: number of digest channels. Channel k (k < `NUM_DIGEST`) owns code address `DIGEST_BASE`+k.
- `DIGEST_BASE`, 32'h5: code address of digest channel 0.
- `TIMEOUT_CYCLES`, 50000: maximum cycles in WAIT_HOST, ≥ 2.
- `CNT_W`, 16: width of the call counter.
- `STOP_ON_ERR`, 1: selects the error mode.
  - 1: the first error parks the FSM in FAULT with no `py_ack`.
  - 0: the error is recorded and the transaction is still acknowledged.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `py_req`  in  1  CPU PYEXEC request.
- `py_code_addr`  in  `DATA_W`  CPU code address; valid while `py_req` is high.
- `py_ack`  out  1  one-cycle acknowledge to the CPU.
- `py_result`  out  `DATA_W`  result returned to the CPU; valid with `py_ack` and held until the next ack.
- `host_req`  out  1  request to the host; level, held until `host_done` or abort.
- `host_code_addr`  out  `DATA_W`  latched code address.
- `host_done`  in  1  host completion strobe.
- `host_rc`  in  `DATA_W`  host return code; valid with `host_done`.
- `digest_valid`  out  `NUM_DIGEST`  channel k has captured its first digest.
- `digest_first`  out  `NUM_DIGEST`*`DATA_W`  first digest per channel; channel k occupies bits [k*`DATA_W` +: `DATA_W`].
- `call_count`  out  `CNT_W`  acknowledged transactions, saturating.
- `err_valid`  out  1  sticky error flag.
- `err_code`  out  3  first error: 0 none, 1 RC_FAIL, 2 DIGEST_ZERO, 3 DIGEST_MISMATCH, 4 TIMEOUT.
- `err_addr`  out  `DATA_W`  code address of the first error.

## Operation

FSM states: IDLE, WAIT_HOST, CHECK, ACK, WAIT_DROP, FAULT.

- **IDLE.**
  - `host_done` is ignored here.
  - On `py_req`=1: latch `py_code_addr` into `host_code_addr`, assert `host_req`, clear the timer, go to WAIT_HOST.
- **WAIT_HOST.**
  - On `host_done`: latch `host_rc`, drop `host_req`, go to CHECK.
  - Otherwise the timer increments each cycle. When it reaches `TIMEOUT_CYCLES`, drop `host_req` and raise TIMEOUT.
    - `STOP_ON_ERR`=1: go to FAULT.
    - `STOP_ON_ERR`=0: the latched rc becomes all-ones; go to ACK.
- **CHECK (one cycle).**
  - Non-digest address with rc≠0: raise RC_FAIL.
  - Digest channel k, rc=0: raise DIGEST_ZERO; the table is unchanged.
  - Digest channel k, `digest_valid[k]`=0: store rc and set valid.
  - Digest channel k, valid, rc≠stored: raise DIGEST_MISMATCH; the stored value is kept.
  - Any raised error goes to FAULT if `STOP_ON_ERR`=1. All other outcomes go to ACK.
- **ACK.** Drive `py_ack`=1 with `py_result`=rc, increment `call_count` (saturating at all-ones), go to WAIT_DROP.
- **WAIT_DROP.** Go to IDLE once `py_req`=0. This guarantees no double issue; the CPU drops `py_req` after `py_ack`.
- **FAULT.** Absorbing until `rst`. `host_req`=0 and `py_ack`=0.

Error recording:
- The first error sets `err_valid`, `err_code` and `err_addr`.
- Later errors do not overwrite them.

## Timing

- All outputs are registered.
- Reset values:
  - state IDLE;
  - `py_ack`, `host_req`, `err_valid` = 0;
  - `py_result`, `host_code_addr`, `err_addr`, `call_count` = 0;
  - `err_code` = 0, `digest_valid` = 0, `digest_first` = 0.
- `py_req` sampled at edge n → `host_req` is high after n.
- `host_done` sampled at edge m → `host_req` is low after m, CHECK runs during m..m+1, and `py_ack` is high for exactly the cycle after edge m+1. Minimum request-to-ack latency is therefore 3 cycles.
- Timeout: `host_req` stays high for exactly `TIMEOUT_CYCLES` cycles with no `host_done`.
  - If `host_done` arrives in the same cycle the timer expires, `host_done` wins.
  - A late `host_done` in IDLE, WAIT_DROP or FAULT is ignored.
- Reset mid-operation: the next edge returns all outputs to reset values, including `host_req` low (the host tolerates an abandoned request) and a cleared digest table.
- A digest address outside [`DIGEST_BASE`, `DIGEST_BASE`+`NUM_DIGEST`-1] is treated as non-digest.

## Test plan

1. **Nominal sequence.** Defaults; addresses 3, 5, 4, 5 with rc 0, 0x1234ABCD, 0, 0x1234ABCD. Required: 4 acks, `call_count`=4, `err_valid`=0, `digest_valid`=2'b01, channel 0 = 0x1234ABCD, `py_result` of the last ack = 0x1234ABCD.
2. **Digest mismatch.** Same sequence, but the second digest rc = 0x1234ABCE. Required: `err_code`=3, `err_addr`=5, no fourth `py_ack`, FSM stays in FAULT for 100 cycles, `call_count`=3.
3. **Zero digest and rc failure.**
   - Digest rc=0 → `err_code`=2 with `digest_valid`=0.
   - Separately, with `STOP_ON_ERR`=0, address 3 with rc=7 → ack with `py_result`=7 and `err_code`=1. A following mismatch does not change `err_code`.
4. **Timeout.** `TIMEOUT_CYCLES`=8 with the host silent. Required: `host_req` high exactly 8 cycles, `err_code`=4.
   - `STOP_ON_ERR`=0: ack with `py_result`=0xFFFFFFFF, and a late `host_done` is ignored.
   - `host_done` on cycle 8: normal ack, no error.
5. **Multi-channel.** `NUM_DIGEST`=2; address 5 rc=0xA, address 6 rc=0xB, address 5 rc=0xA, address 6 rc=0xB. Required: no error, `digest_valid`=2'b11, `digest_first`={0xB,0xA}.
6. **Reset mid-transaction.** `rst` during WAIT_HOST after one digest was captured. Required: all outputs at reset values the next cycle, then a fresh digest is accepted as first.

Source files
------------

// File: rtl/pyexec_host_bridge.sv
// pyexec_host_bridge: services CPU PYEXEC requests through a host mailbox,
// checking return codes and per-channel digest stability, with a host
// watchdog and a selectable stop-on-error / record-and-continue policy.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for py_req; late host_done strobes are ignored
// WAIT_HOST | host_req raised, waiting for host_done or watchdog expiry
// CHECK     | one cycle to classify the latched return code
// ACK       | py_ack high for one cycle, result presented
// WAIT_DROP | waiting for the CPU to release py_req (no double issue)
// FAULT     | absorbing error state until rst
module pyexec_host_bridge #(
    parameter int                DATA_W         = 32,
    parameter int                NUM_DIGEST     = 2,
    parameter logic [DATA_W-1:0] DIGEST_BASE    = 32'h5,
    parameter int                TIMEOUT_CYCLES = 50000,
    parameter int                CNT_W          = 16,
    parameter bit                STOP_ON_ERR    = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         py_req,
    input  logic [DATA_W-1:0]            py_code_addr,
    output logic                         py_ack,
    output logic [DATA_W-1:0]            py_result,
    output logic                         host_req,
    output logic [DATA_W-1:0]            host_code_addr,
    input  logic                         host_done,
    input  logic [DATA_W-1:0]            host_rc,
    output logic [NUM_DIGEST-1:0]        digest_valid,
    output logic [NUM_DIGEST*DATA_W-1:0] digest_first,
    output logic [CNT_W-1:0]             call_count,
    output logic                         err_valid,
    output logic [2:0]                   err_code,
    output logic [DATA_W-1:0]            err_addr
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_HOST = 3'd1,
        S_CHECK     = 3'd2,
        S_ACK       = 3'd3,
        S_WAIT_DROP = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam logic [2:0] ERR_RC_FAIL   = 3'd1;
    localparam logic [2:0] ERR_DIG_ZERO  = 3'd2;
    localparam logic [2:0] ERR_DIG_MISM  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

    // Watchdog is a down-counter: loaded with TIMEOUT_CYCLES-1 when the
    // request is accepted, expiring on the WAIT_HOST edge where it reads zero.
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [TMR_W-1:0]            r_timer;
    logic [DATA_W-1:0]           r_rc;
    logic                        r_py_ack;
    logic [DATA_W-1:0]           r_py_result;
    logic                        r_host_req;
    logic [DATA_W-1:0]           r_host_code_addr;
    logic [NUM_DIGEST-1:0]       r_digest_valid;
    logic [NUM_DIGEST*DATA_W-1:0] r_digest_first;
    logic [CNT_W-1:0]            r_call_count;
    logic                        r_err_valid;
    logic [2:0]                  r_err_code;
    logic [DATA_W-1:0]           r_err_addr;

    logic [DATA_W-1:0]           w_offset;
    logic [NUM_DIGEST-1:0]       w_hit;
    logic                        w_is_digest;
    logic                        w_sel_valid;
    logic [DATA_W-1:0]           w_sel_first;
    logic                        w_raise;
    logic [2:0]                  w_raise_code;
    logic                        w_store;
    logic                        w_timeout;

    assign w_offset    = r_host_code_addr - DIGEST_BASE;
    assign w_is_digest = |w_hit;

    // Decode which digest channel (if any) owns the latched code address.
    always_comb begin
        w_hit       = '0;
        w_sel_valid = 1'b0;
        w_sel_first = '0;
        for (int k = 0; k < NUM_DIGEST; k++) begin
            w_hit[k] = (r_host_code_addr >= DIGEST_BASE) && (w_offset == DATA_W'(k));
            if (w_hit[k]) begin
                w_sel_valid = r_digest_valid[k];
                w_sel_first = r_digest_first[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and error classification.
    always_comb begin
        w_state_nxt  = r_state;
        w_raise      = 1'b0;
        w_raise_code = 3'd0;
        w_store      = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (py_req) w_state_nxt = S_WAIT_HOST;
            end
            S_WAIT_HOST: begin
                if (host_done) begin
                    w_state_nxt = S_CHECK;
                end else if (r_timer == '0) begin
                    w_timeout    = 1'b1;
                    w_raise      = 1'b1;
                    w_raise_code = ERR_TIMEOUT;
                    w_state_nxt  = STOP_ON_ERR ? S_FAULT : S_ACK;
                end
            end
            S_CHECK: begin
                if (!w_is_digest) begin
                    if (r_rc != '0) begin
                        w_raise      = 1'b1;
                        w_raise_code = ERR_RC_FAIL;
                    end
                end else if (r_rc == '0) begin
                    w_raise      = 1'b1;
                    w_raise_code = ERR_DIG_ZERO;
                end else if (!w_sel_valid) begin
                    w_store = 1'b1;
                end else if (r_rc != w_sel_first) begin
                    w_raise      = 1'b1;
                    w_raise_code = ERR_DIG_MISM;
                end
                w_state_nxt = (w_raise && STOP_ON_ERR) ? S_FAULT : S_ACK;
            end
            S_ACK: begin
                w_state_nxt = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!py_req) w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_timer          <= '0;
            r_rc             <= '0;
            r_py_ack         <= 1'b0;
            r_py_result      <= '0;
            r_host_req       <= 1'b0;
            r_host_code_addr <= '0;
            r_digest_valid   <= '0;
            r_digest_first   <= '0;
            r_call_count     <= '0;
            r_err_valid      <= 1'b0;
            r_err_code       <= 3'd0;
            r_err_addr       <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_py_ack <= (w_state_nxt == S_ACK);

            if (r_state == S_IDLE && py_req) begin
                r_host_code_addr <= py_code_addr;
                r_host_req       <= 1'b1;
                r_timer          <= TMR_LOAD;
            end

            if (r_state == S_WAIT_HOST) begin
                if (host_done) begin
                    r_rc       <= host_rc;
                    r_host_req <= 1'b0;
                end else if (w_timeout) begin
                    r_rc       <= '1;
                    r_host_req <= 1'b0;
                end else begin
                    r_timer <= r_timer - TMR_W'(1);
                end
            end

            if (w_state_nxt == S_ACK) begin
                r_py_result <= w_timeout ? '1 : r_rc;
                if (r_call_count != '1) r_call_count <= r_call_count + CNT_W'(1);
            end

            for (int k = 0; k < NUM_DIGEST; k++) begin
                if (w_store && w_hit[k]) begin
                    r_digest_valid[k]                  <= 1'b1;
                    r_digest_first[k*DATA_W +: DATA_W] <= r_rc;
                end
            end

            if (w_raise && !r_err_valid) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_raise_code;
                r_err_addr  <= r_host_code_addr;
            end
        end
    end

    assign py_ack         = r_py_ack;
    assign py_result      = r_py_result;
    assign host_req       = r_host_req;
    assign host_code_addr = r_host_code_addr;
    assign digest_valid   = r_digest_valid;
    assign digest_first   = r_digest_first;
    assign call_count     = r_call_count;
    assign err_valid      = r_err_valid;
    assign err_code       = r_err_code;
    assign err_addr       = r_err_addr;

endmodule

// File: tb/tb_pyexec_host_bridge.sv
// Bench for pyexec_host_bridge: two instances (record-and-continue, index 0;
// stop-on-error, index 1) share stimulus; 'sel' picks the one being observed.
module tb_pyexec_host_bridge;
    localparam int            DW   = 32;
    localparam int            ND   = 2;
    localparam int            TO   = 8;
    localparam int            CW   = 16;
    localparam logic [DW-1:0] BASE = 32'h5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst          = 1'b1;
    logic          py_req       = 1'b0;
    logic          host_done    = 1'b0;
    logic [DW-1:0] py_code_addr = '0;
    logic [DW-1:0] host_rc      = '0;
    logic          sel          = 1'b1;

    logic [1:0]            ack, hreq, ev;
    logic [1:0][DW-1:0]    res, haddr, ea;
    logic [1:0][ND-1:0]    dval;
    logic [1:0][ND*DW-1:0] dfirst;
    logic [1:0][CW-1:0]    cnt;
    logic [1:0][2:0]       ec;

    pyexec_host_bridge #(.DATA_W(DW), .NUM_DIGEST(ND), .DIGEST_BASE(BASE),
        .TIMEOUT_CYCLES(TO), .CNT_W(CW), .STOP_ON_ERR(1'b0)) u_cont (
        .clk(clk), .rst(rst), .py_req(py_req), .py_code_addr(py_code_addr),
        .py_ack(ack[0]), .py_result(res[0]), .host_req(hreq[0]),
        .host_code_addr(haddr[0]), .host_done(host_done), .host_rc(host_rc),
        .digest_valid(dval[0]), .digest_first(dfirst[0]), .call_count(cnt[0]),
        .err_valid(ev[0]), .err_code(ec[0]), .err_addr(ea[0]));

    pyexec_host_bridge #(.DATA_W(DW), .NUM_DIGEST(ND), .DIGEST_BASE(BASE),
        .TIMEOUT_CYCLES(TO), .CNT_W(CW), .STOP_ON_ERR(1'b1)) u_stop (
        .clk(clk), .rst(rst), .py_req(py_req), .py_code_addr(py_code_addr),
        .py_ack(ack[1]), .py_result(res[1]), .host_req(hreq[1]),
        .host_code_addr(haddr[1]), .host_done(host_done), .host_rc(host_rc),
        .digest_valid(dval[1]), .digest_first(dfirst[1]), .call_count(cnt[1]),
        .err_valid(ev[1]), .err_code(ec[1]), .err_addr(ea[1]));

    logic             o_ack, o_hreq, o_ev;
    logic [DW-1:0]    o_res, o_haddr, o_ea;
    logic [ND-1:0]    o_dval;
    logic [ND*DW-1:0] o_dfirst;
    logic [CW-1:0]    o_cnt;
    logic [2:0]       o_ec;
    assign o_ack    = ack[sel];
    assign o_hreq   = hreq[sel];
    assign o_ev     = ev[sel];
    assign o_res    = res[sel];
    assign o_haddr  = haddr[sel];
    assign o_ea     = ea[sel];
    assign o_dval   = dval[sel];
    assign o_dfirst = dfirst[sel];
    assign o_cnt    = cnt[sel];
    assign o_ec     = ec[sel];

    // Reference model: transaction-level view of the bridge.
    typedef struct {
        logic [DW-1:0] res;
        int            cnt;
    } exp_t;
    exp_t          q[$];
    logic [ND-1:0] m_dval;
    logic [DW-1:0] m_dfirst[ND];
    logic          m_ev;
    logic [2:0]    m_ec;
    logic [DW-1:0] m_ea;
    int            m_cnt;
    logic [DW-1:0] m_last_res;
    bit            m_fault;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_dval = '0;
        for (int k = 0; k < ND; k++) m_dfirst[k] = '0;
        m_ev = 1'b0; m_ec = 3'd0; m_ea = '0;
        m_cnt = 0; m_last_res = '0; m_fault = 1'b0;
        q.delete();
    endtask

    task automatic model_txn(input logic [DW-1:0] addr, input logic [DW-1:0] rc, input bit silent);
        logic [2:0]    err;
        logic [DW-1:0] r;
        int            ch;
        err = 3'd0;
        r   = rc;
        if (silent) begin
            err = 3'd4;
            r   = '1;
        end else if (addr >= BASE && addr < BASE + DW'(ND)) begin
            ch = int'(addr - BASE);
            if (rc == '0) err = 3'd2;
            else if (!m_dval[ch]) begin
                m_dval[ch]   = 1'b1;
                m_dfirst[ch] = rc;
            end else if (rc != m_dfirst[ch]) err = 3'd3;
        end else if (rc != '0) begin
            err = 3'd1;
        end
        if (err != 3'd0 && !m_ev) begin
            m_ev = 1'b1; m_ec = err; m_ea = addr;
        end
        if (err != 3'd0 && sel) begin
            m_fault = 1'b1;
        end else begin
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_last_res = r;
            q.push_back('{r, m_cnt});
        end
    endtask

    // Monitor: every ack pops one expected response.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && o_ack) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: py_result=%0h, required no ack", o_res);
            end else begin
                mon_e = q.pop_front();
                chk("ack_result", o_res, mon_e.res);
                chk("ack_call_count", o_cnt, CW'(mon_e.cnt));
            end
        end
    end

    task automatic check_state(input string tag);
        logic [ND*DW-1:0] exp_df;
        for (int k = 0; k < ND; k++) exp_df[k*DW +: DW] = m_dfirst[k];
        chk({tag, ".err_valid"}, o_ev, m_ev);
        chk({tag, ".err_code"}, o_ec, m_ec);
        chk({tag, ".err_addr"}, o_ea, m_ea);
        chk({tag, ".call_count"}, o_cnt, CW'(m_cnt));
        chk({tag, ".digest_valid"}, o_dval, m_dval);
        chk({tag, ".digest_first"}, o_dfirst, exp_df);
        chk({tag, ".py_result"}, o_res, m_last_res);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".py_ack"}, o_ack, 0);
        chk({tag, ".py_result"}, o_res, 0);
        chk({tag, ".host_req"}, o_hreq, 0);
        chk({tag, ".host_code_addr"}, o_haddr, 0);
        chk({tag, ".err_valid"}, o_ev, 0);
        chk({tag, ".err_code"}, o_ec, 0);
        chk({tag, ".err_addr"}, o_ea, 0);
        chk({tag, ".call_count"}, o_cnt, 0);
        chk({tag, ".digest_valid"}, o_dval, 0);
        chk({tag, ".digest_first"}, o_dfirst, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; py_req = 1'b0; host_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_txn(input logic [DW-1:0] addr, input logic [DW-1:0] rc,
                          input bit silent, input int dly);
        int n;
        int hold;
        bit seen;
        model_txn(addr, rc, silent);
        @(negedge clk);
        py_req = 1'b1;
        py_code_addr = addr;
        n = 0;
        while (!o_hreq && n < 10) begin @(negedge clk); n++; end
        chk("req_latency", n, 1);
        chk("host_code_addr", o_haddr, addr);
        if (silent) begin
            n = 0;
            while (o_hreq && n < TO + 4) begin @(negedge clk); n++; end
            chk("timeout_host_req_len", n, TO);
        end else begin
            repeat (dly) @(negedge clk);
            host_done = 1'b1;
            host_rc   = rc;
            @(negedge clk);
            host_done = 1'b0;
            host_rc   = $urandom;
            chk("host_req_drop", o_hreq, 0);
        end
        if (m_fault) begin
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                host_done = (i == 3);
                @(negedge clk);
                if (o_ack || o_hreq) seen = 1'b1;
            end
            host_done = 1'b0;
            chk("fault_quiet", seen, 0);
            py_req = 1'b0;
        end else begin
            n = 0;
            while (!o_ack && n < 10) begin @(negedge clk); n++; end
            chk("ack_latency", n, silent ? 0 : 1);
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                chk("no_double_issue", o_hreq, 0);
            end
            py_req = 1'b0;
            if (silent) begin
                @(negedge clk);
                host_done = 1'b1; host_rc = $urandom;
                @(negedge clk);
                host_done = 1'b0;
                repeat (4) @(negedge clk);
                chk("late_done_ignored", o_hreq, 0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [DW-1:0] a, r;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Nominal sequence
        sel = 1'b1; do_reset();
        do_txn(3, 32'h0, 0, 0);
        do_txn(5, 32'h1234ABCD, 0, 2);
        do_txn(4, 32'h0, 0, 1);
        do_txn(5, 32'h1234ABCD, 0, 5);
        check_state("nominal");

        // Digest mismatch parks in FAULT
        do_reset();
        do_txn(3, 32'h0, 0, 0);
        do_txn(5, 32'h1234ABCD, 0, 0);
        do_txn(4, 32'h0, 0, 3);
        do_txn(5, 32'h1234ABCE, 0, 1);
        check_state("mismatch");

        // Zero digest
        do_reset();
        do_txn(5, 32'h0, 0, 2);
        check_state("digest_zero");

        // rc failure recorded, later mismatch does not overwrite
        sel = 1'b0; do_reset();
        do_txn(3, 32'h7, 0, 0);
        do_txn(5, 32'hA, 0, 1);
        do_txn(5, 32'hB, 0, 4);
        check_state("rc_fail_continue");

        // Timeout, stop-on-error
        sel = 1'b1; do_reset();
        do_txn(3, 32'h0, 1, 0);
        check_state("timeout_stop");

        // Timeout, record-and-continue, late host_done ignored
        sel = 1'b0; do_reset();
        do_txn(3, 32'h0, 1, 0);
        check_state("timeout_cont");

        // host_done on the final watchdog cycle wins
        sel = 1'b1; do_reset();
        do_txn(5, 32'hA, 0, TO - 1);
        check_state("done_at_expiry");

        // Multi-channel
        do_reset();
        do_txn(5, 32'hA, 0, 0);
        do_txn(6, 32'hB, 0, 3);
        do_txn(5, 32'hA, 0, 7);
        do_txn(6, 32'hB, 0, 1);
        check_state("multi_channel");

        // Reset in WAIT_HOST after one digest was captured
        do_reset();
        do_txn(5, 32'hA, 0, 0);
        @(negedge clk);
        py_req = 1'b1; py_code_addr = 6;
        @(negedge clk);
        chk("midrst_in_wait", o_hreq, 1);
        rst = 1'b1; py_req = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        model_reset();
        do_txn(5, 32'hC, 0, 2);
        check_state("after_midrst");

        // Randomized traffic on both error policies
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 5))
                    0: a = 3;
                    1: a = 4;
                    2: a = 5;
                    3: a = 6;
                    4: a = 7;
                    default: a = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0: r = 32'h0;
                    1: r = 32'hA;
                    2: r = 32'hB;
                    default: r = $urandom;
                endcase
                do_txn(a, r, ($urandom_range(0, 9) == 0), $urandom_range(0, TO - 1));
                if (m_fault) begin
                    check_state("rnd_fault");
                    do_reset();
                end
            end
            check_state("rnd_end");
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
